// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundles for mem_port_arbiter.
// Requesters drive the master modport; the arbiter takes slave.
interface mem_port_arbiter_if #(
    parameter int REQ_CNT = 4
);
    logic [REQ_CNT-1:0]       req_valid;
    logic [REQ_CNT-1:0][31:0] req_addr;
    logic [REQ_CNT-1:0]       req_write;
    logic [REQ_CNT-1:0][31:0] req_wdata;
    logic [REQ_CNT-1:0]       req_rdy;
    logic [REQ_CNT-1:0]       rsp_valid;
    logic                     rsp_err;
    logic [31:0]              rsp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_rdy, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_rdy, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

interface sys_mem_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_write;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata,
        input  mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata,
        output mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-word sys_mem port.
// One outstanding transaction; a watchdog bounds the wait.
module mem_port_arbiter #(
    parameter int req_cnt        = 4,
    parameter int timeout_cycles = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    mem_port_arbiter_if.slave req_bus,
    sys_mem_if.master    mem_bus,
    output logic         busy
);
    localparam int GW = (req_cnt > 1) ? $clog2(req_cnt) : 1;
    localparam int CW = $clog2(timeout_cycles);
    localparam logic [GW-1:0] LAST_IDX = GW'(req_cnt - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(timeout_cycles - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state, w_state;
    logic [GW-1:0]      r_rr_ptr, w_rr_ptr;
    logic [GW-1:0]      r_grant, w_grant;
    logic [CW-1:0]      r_wait_cnt, w_wait_cnt;
    logic [req_cnt-1:0] r_req_rdy, w_req_rdy;
    logic [req_cnt-1:0] r_rsp_valid, w_rsp_valid;
    logic               r_rsp_err, w_rsp_err;
    logic [31:0]        r_rsp_rdata, w_rsp_rdata;
    logic               r_mem_valid, w_mem_valid;
    logic [31:0]        r_mem_addr, w_mem_addr;
    logic               r_mem_write, w_mem_write;
    logic [31:0]        r_mem_wdata, w_mem_wdata;

    logic               w_any;
    logic [GW-1:0]      w_pick;
    logic [GW-1:0]      w_rr_next;

    // Scan downward so the requester closest to rr_ptr wins last.
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = req_cnt - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % req_cnt;
            if (req_bus.req_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = GW'(idx);
            end
        end
    end

    assign w_rr_next = (r_grant == LAST_IDX) ? '0 : r_grant + GW'(1);

    always_comb begin
        w_state     = r_state;
        w_rr_ptr    = r_rr_ptr;
        w_grant     = r_grant;
        w_wait_cnt  = r_wait_cnt;
        w_req_rdy   = '0;
        w_rsp_valid = '0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_mem_valid = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_write = r_mem_write;
        w_mem_wdata = r_mem_wdata;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant           = w_pick;
                    w_mem_addr        = req_bus.req_addr[w_pick];
                    w_mem_write       = req_bus.req_write[w_pick];
                    w_mem_wdata       = req_bus.req_wdata[w_pick];
                    w_req_rdy[w_pick] = 1'b1;
                    w_mem_valid       = 1'b1;
                    w_wait_cnt        = '0;
                    w_state           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_bus.mem_rsp_valid) begin
                    w_rsp_valid[r_grant] = 1'b1;
                    w_rsp_rdata = r_mem_write ? 32'h0
                                              : mem_bus.mem_rsp_rdata;
                    w_rr_ptr    = w_rr_next;
                    w_state     = S_IDLE;
                end else if (r_wait_cnt == TO_LAST) begin
                    w_rsp_valid[r_grant] = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_rdata = 32'h0;
                    w_rr_ptr    = w_rr_next;
                    w_state     = S_IDLE;
                end else begin
                    w_wait_cnt = r_wait_cnt + CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_wait_cnt  <= '0;
            r_req_rdy   <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= 32'h0;
        end else if (en) begin
            r_state     <= w_state;
            r_rr_ptr    <= w_rr_ptr;
            r_grant     <= w_grant;
            r_wait_cnt  <= w_wait_cnt;
            r_req_rdy   <= w_req_rdy;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_rsp_rdata <= w_rsp_rdata;
            r_mem_valid <= w_mem_valid;
            r_mem_addr  <= w_mem_addr;
            r_mem_write <= w_mem_write;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    assign req_bus.req_rdy       = r_req_rdy;
    assign req_bus.rsp_valid     = r_rsp_valid;
    assign req_bus.rsp_err       = r_rsp_err;
    assign req_bus.rsp_rdata     = r_rsp_rdata;
    assign mem_bus.mem_req_valid = r_mem_valid;
    assign mem_bus.mem_req_addr  = r_mem_addr;
    assign mem_bus.mem_req_write = r_mem_write;
    assign mem_bus.mem_req_wdata = r_mem_wdata;
    assign busy                  = (r_state == S_WAIT);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-scenario tasks with inline checks
// plus a response scoreboard filled when requests are driven.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        en_q = 1'b1;
    logic        zw = 1'b0;
    logic        tb_rsp_v = 1'b0;
    logic [31:0] tb_rdata = 32'h0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    mem_port_arbiter_if #(.REQ_CNT(N)) rbus();
    sys_mem_if mbus();

    // Zero-wait memory answers in the same cycle as the issue pulse.
    assign mbus.mem_rsp_valid = tb_rsp_v | (zw & mbus.mem_req_valid);
    assign mbus.mem_rsp_rdata = zw ? (mbus.mem_req_addr ^ 32'hA5A5_0000)
                                   : tb_rdata;

    mem_port_arbiter #(.req_cnt(N), .timeout_cycles(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req_bus (rbus),
        .mem_bus (mbus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_q <= en;

    // A fresh pulse is one produced by an enabled edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [N-1:0] oh;
        if (en_q && |rbus.rsp_valid) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected rsp_valid=%b", rbus.rsp_valid);
            end else begin
                e = sbq.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                if (rbus.rsp_valid !== oh || rbus.rsp_err !== e.err ||
                    rbus.rsp_rdata !== e.data) begin
                    n_bad++;
                    $display("FAIL sb_rsp got v=%b e=%b d=%h want v=%b e=%b d=%h",
                             rbus.rsp_valid, rbus.rsp_err, rbus.rsp_rdata,
                             oh, e.err, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic w, input logic [31:0] d);
        rbus.req_valid[i] = 1'b1;
        rbus.req_addr[i]  = a;
        rbus.req_write[i] = w;
        rbus.req_wdata[i] = d;
    endtask

    task automatic push(input int i, input logic e, input logic [31:0] d);
        exp_t x;
        x.idx = i;
        x.err = e;
        x.data = d;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++; if (rbus.req_rdy !== 4'b0) begin n_bad++; $display("FAIL rst_rdy got=%b want=0", rbus.req_rdy); end
        n_cmp++; if (rbus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_rspv got=%b want=0", rbus.rsp_valid); end
        n_cmp++; if (mbus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_memv got=%b want=0", mbus.mem_req_valid); end
        n_cmp++; if (mbus.mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h want=0", mbus.mem_req_addr); end
        rst = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        logic [N-1:0] er;
        zw = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        for (int k = 0; k < 6; k++)
            push(seq[k], 1'b0, (32'h1000 + 32'(seq[k] * 4)) ^ 32'hA5A5_0000);
        for (int c = 1; c <= 11; c++) begin
            tick();
            er = '0;
            if (c % 2 == 1) er[seq[(c - 1) / 2]] = 1'b1;
            n_cmp++;
            if (rbus.req_rdy !== er) begin
                n_bad++;
                $display("FAIL rr_grant cyc=%0d got=%b want=%b", c, rbus.req_rdy, er);
            end
        end
        rbus.req_valid = '0;
        tick();
        zw = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        set_req(2, 32'h100, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL rd_rdy got=%b want=0100", rbus.req_rdy); end
        n_cmp++; if (mbus.mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rd_memv got=%b want=1", mbus.mem_req_valid); end
        n_cmp++; if (mbus.mem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr got=%h want=100", mbus.mem_req_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy1 got=%b want=1", busy); end
        rbus.req_valid = '0;
        push(2, 1'b0, 32'hDEAD_BEEF);
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy2 got=%b want=1", busy); end
        n_cmp++; if (mbus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_memv2 got=%b want=0", mbus.mem_req_valid); end
        tb_rsp_v = 1'b1;
        tb_rdata = 32'hDEAD_BEEF;
        tick();
        tb_rsp_v = 1'b0;
        n_cmp++; if (rbus.rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL rd_rspv got=%b want=0100", rbus.rsp_valid); end
        n_cmp++; if (rbus.rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got=%h want=deadbeef", rbus.rsp_rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy3 got=%b want=0", busy); end
    endtask

    task automatic test_wrap_skip();
        set_req(1, 32'h300, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL skip_rdy got=%b want=0010", rbus.req_rdy); end
        rbus.req_valid = '0;
        push(1, 1'b0, 32'h1111_0000);
        tb_rsp_v = 1'b1;
        tb_rdata = 32'h1111_0000;
        tick();
        tb_rsp_v = 1'b0;
        n_cmp++; if (rbus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL same_cyc_rsp got=%b want=0010", rbus.rsp_valid); end
        set_req(0, 32'h400, 1'b0, 32'h0);
        set_req(1, 32'h404, 1'b0, 32'h0);
        set_req(2, 32'h408, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL ptr2_rdy got=%b want=0100", rbus.req_rdy); end
        rbus.req_valid = '0;
        push(2, 1'b0, 32'h2222_0000);
        tb_rsp_v = 1'b1;
        tb_rdata = 32'h2222_0000;
        tick();
        tb_rsp_v = 1'b0;
        set_req(0, 32'h410, 1'b0, 32'h0);
        set_req(1, 32'h414, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL wrap_rdy got=%b want=0001", rbus.req_rdy); end
        rbus.req_valid = '0;
        push(0, 1'b0, 32'h3333_0000);
        tb_rsp_v = 1'b1;
        tb_rdata = 32'h3333_0000;
        tick();
        tb_rsp_v = 1'b0;
    endtask

    task automatic test_write_timeout();
        set_req(3, 32'h200, 1'b1, 32'h1234_5678);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b1000) begin n_bad++; $display("FAIL wr_rdy got=%b want=1000", rbus.req_rdy); end
        n_cmp++; if (mbus.mem_req_write !== 1'b1) begin n_bad++; $display("FAIL wr_flag got=%b want=1", mbus.mem_req_write); end
        n_cmp++; if (mbus.mem_req_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_data got=%h want=12345678", mbus.mem_req_wdata); end
        rbus.req_valid = '0;
        push(3, 1'b1, 32'h0);
        for (int c = 2; c <= TO; c++) begin
            tick();
            n_cmp++;
            if (rbus.rsp_valid !== 4'b0) begin
                n_bad++;
                $display("FAIL to_early cyc=%0d got=%b want=0", c, rbus.rsp_valid);
            end
        end
        tick();
        n_cmp++; if (rbus.rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL to_rspv got=%b want=1000", rbus.rsp_valid); end
        n_cmp++; if (rbus.rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_err got=%b want=1", rbus.rsp_err); end
        n_cmp++; if (rbus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_data got=%h want=0", rbus.rsp_rdata); end
        set_req(0, 32'h500, 1'b1, 32'hAAAA_5555);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL after_to_rdy got=%b want=0001", rbus.req_rdy); end
        rbus.req_valid = '0;
        push(0, 1'b0, 32'h0);
        tb_rsp_v = 1'b1;
        tb_rdata = 32'hFFFF_FFFF;
        tick();
        tb_rsp_v = 1'b0;
        n_cmp++; if (rbus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b want=0", rbus.rsp_err); end
        n_cmp++; if (rbus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got=%h want=0", rbus.rsp_rdata); end
    endtask

    task automatic test_freeze();
        set_req(1, 32'h600, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL fz_rdy got=%b want=0010", rbus.req_rdy); end
        rbus.req_valid = '0;
        en = 1'b0;
        push(1, 1'b1, 32'h0);
        for (int f = 0; f < 5; f++) begin
            tick();
            n_cmp++;
            if (rbus.req_rdy !== 4'b0010 || mbus.mem_req_valid !== 1'b1 ||
                busy !== 1'b1 || rbus.rsp_valid !== 4'b0) begin
                n_bad++;
                $display("FAIL fz_hold f=%0d got rdy=%b memv=%b busy=%b rspv=%b want 0010/1/1/0000",
                         f, rbus.req_rdy, mbus.mem_req_valid, busy, rbus.rsp_valid);
            end
            tb_rsp_v = (f == 1);
            tb_rdata = 32'h0000_0BAD;
        end
        tb_rsp_v = 1'b0;
        en = 1'b1;
        for (int c = 1; c < TO; c++) begin
            tick();
            n_cmp++;
            if (rbus.rsp_valid !== 4'b0 || rbus.req_rdy !== 4'b0) begin
                n_bad++;
                $display("FAIL fz_wait c=%0d got rspv=%b rdy=%b want 0", c, rbus.rsp_valid, rbus.req_rdy);
            end
        end
        tick();
        n_cmp++; if (rbus.rsp_valid !== 4'b0010 || rbus.rsp_err !== 1'b1) begin n_bad++; $display("FAIL fz_to got v=%b e=%b want 0010/1", rbus.rsp_valid, rbus.rsp_err); end
    endtask

    task automatic test_reset_mid_wait();
        set_req(2, 32'h700, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL rw_rdy got=%b want=0100", rbus.req_rdy); end
        rbus.req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (rbus.req_rdy !== 4'b0 || rbus.rsp_valid !== 4'b0 || rbus.rsp_err !== 1'b0 ||
            rbus.rsp_rdata !== 32'h0 || mbus.mem_req_valid !== 1'b0 ||
            mbus.mem_req_addr !== 32'h0 || mbus.mem_req_write !== 1'b0 ||
            mbus.mem_req_wdata !== 32'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_outs got rdy=%b rspv=%b addr=%h busy=%b want all 0",
                     rbus.req_rdy, rbus.rsp_valid, mbus.mem_req_addr, busy);
        end
        rst = 1'b0;
        tb_rsp_v = 1'b1;
        tb_rdata = 32'h0000_0999;
        tick();
        tb_rsp_v = 1'b0;
        n_cmp++; if (rbus.rsp_valid !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stale_rsp got v=%b busy=%b want 0/0", rbus.rsp_valid, busy); end
        tick();
        n_cmp++; if (rbus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL stale_rsp2 got=%b want=0", rbus.rsp_valid); end
        set_req(1, 32'h800, 1'b0, 32'h0);
        set_req(3, 32'h804, 1'b0, 32'h0);
        tick();
        n_cmp++; if (rbus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL rw_ptr0 got=%b want=0010", rbus.req_rdy); end
        rbus.req_valid = '0;
        push(1, 1'b0, 32'h4444_0000);
        tb_rsp_v = 1'b1;
        tb_rdata = 32'h4444_0000;
        tick();
        tb_rsp_v = 1'b0;
        tick();
    endtask

    initial begin
        rbus.req_valid = '0;
        rbus.req_addr  = '0;
        rbus.req_write = '0;
        rbus.req_wdata = '0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_wrap_skip();
        test_write_timeout();
        test_freeze();
        test_reset_mid_wait();
        tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got=%0d want=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
